pb_step_conditioner: RTL and testbench

Conditions one raw pushbutton into a clean, single-cycle `step` pulse on the `hz100` domain. It is the stage directly upstream of the ring-counter / shift-register stages, which otherwise take a bouncing button as their clock. The block synchronises, debounces and optionally auto-repeats while the button is held, and counts the pulses it emits. Downstream stages consume `step` as a clock enable on `hz100`, never as a clock.

---
 rtl/pb_cond_pkg.sv | 19 +
 rtl/pb_sync2.sv | 22 ++
 rtl/pb_step_conditioner.sv | 138 +++++++++++++
 tb/tb_pb_step_conditioner.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/pb_cond_pkg.sv
// rtl/pb_cond_pkg.sv - shared types and constants for the pushbutton step conditioner
package pb_cond_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_CHK,
    PRESSED,
    REPEAT,
    RELEASE_CHK
  } pb_state_t;

  localparam int STEP_CNT_W = 8;

  // Larger of two integers, used to size the shared hold counter
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pb_sync2.sv
// rtl/pb_sync2.sv - two-flop synchroniser for an asynchronous level
module pb_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; only q is safe to use downstream
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pb_step_conditioner.sv
// rtl/pb_step_conditioner.sv - debounce, auto-repeat and count a pushbutton into a step enable
module pb_step_conditioner
  import pb_cond_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 5,
  parameter int REPEAT_DELAY   = 50,
  parameter int REPEAT_PERIOD  = 10
) (
  input  logic                  hz100,
  input  logic                  reset,
  input  logic                  btn_raw,
  input  logic                  repeat_en,
  output logic                  step,
  output logic                  level,
  output logic [STEP_CNT_W-1:0] step_count
);

  localparam int DEB_W  = $clog2(DEBOUNCE_TICKS + 1);
  localparam int HOLD_W = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);

  // Counters hold "samples seen so far minus one" at the decision point, so the
  // accepting sample is the one that brings the run up to the full threshold.
  localparam logic [DEB_W-1:0]  DEB_LAST    = DEB_W'(DEBOUNCE_TICKS - 1);
  localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);

  pb_state_t         state;
  logic              btn_s;
  logic [DEB_W-1:0]  deb_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_last;

  pb_sync2 u_sync (
    .clk   (hz100),
    .reset (reset),
    .d     (btn_raw),
    .q     (btn_s)
  );

  // First repeat waits the long delay, later repeats use the short period
  always_comb begin
    hold_last = DELAY_LAST;
    if (state == REPEAT) hold_last = PERIOD_LAST;
  end

  // Debounce / repeat state machine; step and level are registered here
  always_ff @(posedge hz100) begin
    if (reset) begin
      state    <= IDLE;
      deb_cnt  <= '0;
      hold_cnt <= '0;
      step     <= 1'b0;
      level    <= 1'b0;
    end else begin
      step <= 1'b0;
      case (state)
        IDLE: begin
          if (btn_s) begin
            if (DEB_LAST == '0) begin
              state    <= PRESSED;
              step     <= 1'b1;
              level    <= 1'b1;
              hold_cnt <= '0;
              deb_cnt  <= '0;
            end else begin
              state   <= PRESS_CHK;
              deb_cnt <= DEB_W'(1);
            end
          end
        end
        PRESS_CHK: begin
          if (!btn_s) begin
            state   <= IDLE;
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            state    <= PRESSED;
            step     <= 1'b1;
            level    <= 1'b1;
            hold_cnt <= '0;
            deb_cnt  <= '0;
          end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
          end
        end
        PRESSED, REPEAT: begin
          if (!btn_s) begin
            hold_cnt <= '0;
            if (DEB_LAST == '0) begin
              state   <= IDLE;
              level   <= 1'b0;
              deb_cnt <= '0;
            end else begin
              state   <= RELEASE_CHK;
              deb_cnt <= DEB_W'(1);
            end
          end else if (!repeat_en) begin
            hold_cnt <= '0;
          end else if (hold_cnt == hold_last) begin
            step     <= 1'b1;
            hold_cnt <= '0;
            state    <= REPEAT;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        RELEASE_CHK: begin
          if (btn_s) begin
            state    <= PRESSED;
            hold_cnt <= '0;
            deb_cnt  <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            state   <= IDLE;
            level   <= 1'b0;
            deb_cnt <= '0;
          end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          deb_cnt  <= '0;
          hold_cnt <= '0;
          level    <= 1'b0;
        end
      endcase
    end
  end

  // Running count of emitted steps, wrapping naturally at the counter width
  always_ff @(posedge hz100) begin
    if (reset) begin
      step_count <= '0;
    end else if (step) begin
      step_count <= step_count + STEP_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pb_step_conditioner.sv
// tb/tb_pb_step_conditioner.sv - scoreboard bench for the pushbutton step conditioner
module tb_pb_step_conditioner;

  typedef struct {
    int         edge_no;
    logic [7:0] cnt;
  } exp_t;

  logic       hz100;
  logic       reset;
  logic       btn_raw;
  logic       repeat_en;
  logic       step;
  logic       level;
  logic [7:0] step_count;

  int   edge_n = 0;
  int   n_checks = 0;
  int   n_err = 0;
  int   cnt_model = 0;
  exp_t exp_q[$];
  logic cnt_pending = 1'b0;
  int   pend_cnt = 0;

  int e0, p0, r0, b5;
  int pat[6] = '{1, 0, 1, 1, 0, 1};

  pb_step_conditioner dut (
    .hz100      (hz100),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .repeat_en  (repeat_en),
    .step       (step),
    .level      (level),
    .step_count (step_count)
  );

  initial begin
    hz100 = 1'b0;
    forever #5 hz100 = ~hz100;
  end

  always @(posedge hz100) edge_n <= edge_n + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge hz100);
  endtask

  task automatic push(input int e);
    exp_t x;
    cnt_model = (cnt_model + 1) % 256;
    x.edge_no = e;
    x.cnt     = cnt_model[7:0];
    exp_q.push_back(x);
  endtask

  // Monitor: every step pulse must match the next expected edge, then the count
  always @(negedge hz100) begin
    if (cnt_pending) begin
      chk("step_count", int'(step_count), pend_cnt);
      cnt_pending = 1'b0;
    end
    if (step === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_step", 1, 0);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        chk("step_edge", edge_n, x.edge_no);
        pend_cnt    = int'(x.cnt);
        cnt_pending = 1'b1;
      end
    end
  end

  initial begin
    reset = 1'b1; btn_raw = 1'b0; repeat_en = 1'b0;
    cyc(3);
    chk("reset_step", int'(step), 0);
    chk("reset_level", int'(level), 0);
    chk("reset_count", int'(step_count), 0);
    reset = 1'b0;
    cyc(2);

    // clean press, no repeat
    btn_raw = 1'b1; e0 = edge_n + 1; push(e0 + 6);
    cyc(6); chk("press_level_pre", int'(level), 0);
    cyc(1); chk("press_level_post", int'(level), 1);
    cyc(14);
    btn_raw = 1'b0; r0 = edge_n + 1;
    cyc(6); chk("release_level_pre", int'(level), 1);
    cyc(1); chk("release_level_post", int'(level), 0);
    cyc(4);

    // bouncing press
    for (int i = 0; i < 6; i++) begin
      btn_raw = pat[i][0];
      if (i == 5) b5 = edge_n + 1;
      cyc(1);
    end
    push(b5 + 6);
    cyc(20);
    chk("bounce_level", int'(level), 1);
    btn_raw = 1'b0;
    cyc(10);

    // auto-repeat held for 100 cycles after the initial pulse
    repeat_en = 1'b1; btn_raw = 1'b1; e0 = edge_n + 1; p0 = e0 + 6;
    push(p0);
    for (int k = 50; k <= 100; k += 10) push(p0 + k);
    cyc(p0 + 100 - edge_n);
    btn_raw = 1'b0;
    cyc(10);
    chk("repeat_release_level", int'(level), 0);
    repeat_en = 1'b0;

    // release glitch of 3 cycles is rejected
    btn_raw = 1'b1; e0 = edge_n + 1; push(e0 + 6);
    cyc(15);
    btn_raw = 1'b0; cyc(3); btn_raw = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      chk("glitch_level", int'(level), 1);
    end
    btn_raw = 1'b0;
    cyc(6); chk("long_release_pre", int'(level), 1);
    cyc(1); chk("long_release_post", int'(level), 0);
    cyc(4);

    // reset while repeating with the button held
    repeat_en = 1'b1; btn_raw = 1'b1; e0 = edge_n + 1; p0 = e0 + 6;
    push(p0); push(p0 + 50);
    cyc(p0 + 55 - edge_n);
    reset = 1'b1;
    cyc(1);
    chk("midreset_step", int'(step), 0);
    chk("midreset_level", int'(level), 0);
    chk("midreset_count", int'(step_count), 0);
    cnt_model = 0;
    cyc(1);
    reset = 1'b0; repeat_en = 1'b0;
    push(edge_n + 7);
    cyc(6); chk("after_reset_level_pre", int'(level), 0);
    cyc(1); chk("after_reset_level_post", int'(level), 1);
    cyc(5);
    btn_raw = 1'b0;
    cyc(10);

    // 255 more presses wrap the count from 1 back to 0
    for (int i = 0; i < 255; i++) begin
      btn_raw = 1'b1; push(edge_n + 7);
      cyc(8);
      btn_raw = 1'b0;
      cyc(8);
    end
    cyc(4);
    chk("wrap_count", int'(step_count), 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
